// File: rtl/vec_mem_serializer.sv
// Serializes one LANES x N vector request into LANES single-lane accesses on a
// narrow synchronous RAM port, and gathers read lanes back into one vector.
module vec_mem_serializer #(
  parameter int N     = 16,
  parameter int LANES = 16,
  parameter int AW    = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [AW-1:0]      req_addr,
  input  logic [LANES*N-1:0] req_wdata,
  output logic               resp_valid,
  output logic [LANES*N-1:0] resp_rdata,
  output logic               busy,
  output logic               mem_en,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [N-1:0]       mem_wdata,
  input  logic [N-1:0]       mem_rdata,
  output logic [2:0]         state_dbg
);

  // Handshake: a request transfers on the rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, so a request arriving while busy is simply held
  // off (not queued) until the requester sees req_ready.

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      cnt, cnt_next, cnt_prev;
  logic [AW-1:0]      base, base_next;
  logic [LANES*N-1:0] wbuf, wbuf_next, gather;
  logic               accept, issue_next;

  assign accept     = req_valid && req_ready;
  assign cnt_prev   = cnt - 1'b1;
  assign issue_next = (state_next == WRITE) || (state_next == READ);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_next   = '0;
    base_next  = base;
    wbuf_next  = wbuf;
    unique case (state)
      IDLE: if (accept) begin
        state_next = req_write ? WRITE : READ;
        base_next  = req_addr;
        wbuf_next  = req_wdata;
      end
      WRITE: if (cnt == LAST) state_next = DONE;
             else             cnt_next   = cnt + 1'b1;
      READ:  if (cnt == LAST) state_next = DRAIN;
             else             cnt_next   = cnt + 1'b1;
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    busy       = (state != IDLE);
    resp_valid = (state == DONE);
    state_dbg  = state;
  end

  // RAM port registers are loaded from the next-cycle lane so they line up with
  // the state that issues them; address arithmetic wraps modulo 2^AW.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt        <= '0;
      base       <= '0;
      wbuf       <= '0;
      gather     <= '0;
      resp_rdata <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      cnt       <= cnt_next;
      base      <= base_next;
      wbuf      <= wbuf_next;
      mem_en    <= issue_next;
      mem_we    <= (state_next == WRITE);
      mem_addr  <= issue_next ? AW'(base_next + AW'(cnt_next)) : '0;
      mem_wdata <= (state_next == WRITE) ? wbuf_next[cnt_next*N +: N] : '0;
      if (state == READ && cnt != '0)
        gather[cnt_prev*N +: N] <= mem_rdata;
      // Last lane arrives in DRAIN; the full vector is visible during DONE.
      if (state == DRAIN)
        resp_rdata <= {mem_rdata, gather[(LANES-1)*N-1:0]};
    end
  end

endmodule

// File: tb/tb_vec_mem_serializer.sv
// Directed and randomized store/load traffic against a synchronous RAM model,
// with queued expectations for RAM accesses and responses.
module tb_vec_mem_serializer;

  localparam int N     = 16;
  localparam int LANES = 16;
  localparam int AW    = 16;
  localparam int VW    = LANES * N;
  localparam int MW    = 1 + AW + N;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic           req_write = 1'b0;
  logic [AW-1:0]  req_addr = '0;
  logic [VW-1:0]  req_wdata = '0;
  logic           resp_valid;
  logic [VW-1:0]  resp_rdata;
  logic           busy;
  logic           mem_en;
  logic           mem_we;
  logic [AW-1:0]  mem_addr;
  logic [N-1:0]   mem_wdata;
  logic [N-1:0]   mem_rdata = '0;
  logic [2:0]     state_dbg;

  vec_mem_serializer #(.N(N), .LANES(LANES), .AW(AW)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- RAM model ----------------
  logic [N-1:0] ram [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // ---------------- scoreboard ----------------
  logic [VW-1:0] exp_q[$];
  int            exp_lat_q[$];
  int            acc_q[$];
  logic [MW-1:0] exp_mem_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            last_acc = 0;
  int            last_resp_cyc = 0;
  logic [VW-1:0] model_rdata = '0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    if (RST && resp_valid) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", VW'(resp_valid), '0);
      end else begin
        check("resp_rdata", resp_rdata, exp_q.pop_front());
        check("resp_latency", VW'(cyc - acc_q.pop_front() + 1), VW'(exp_lat_q.pop_front()));
      end
      last_resp_cyc = cyc;
    end
    if (RST && mem_en) begin
      if (exp_mem_q.size() == 0) check("mem_unexpected", VW'(mem_en), '0);
      else check("mem_access", VW'({mem_we, mem_addr, mem_wdata}), VW'(exp_mem_q.pop_front()));
    end
  end

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [VW-1:0] wd,
                       input logic [VW-1:0] exp_rd, input bit track_resp, input int n_mem);
    int waited = 0;
    logic [AW-1:0] a;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    while (!req_ready && waited < 200) begin
      @(negedge CLK);
      waited++;
    end
    if (!req_ready) begin
      check("accept_timeout", VW'(req_ready), VW'(1));
      req_valid = 1'b0;
      return;
    end
    last_acc = cyc + 1;
    for (int i = 0; i < n_mem; i++) begin
      a = addr + AW'(i);
      exp_mem_q.push_back(wr ? {1'b1, a, wd[i*N +: N]} : {1'b0, a, {N{1'b0}}});
    end
    if (track_resp) begin
      if (!wr) model_rdata = exp_rd;
      exp_q.push_back(model_rdata);
      exp_lat_q.push_back(wr ? LANES + 1 : LANES + 2);
      acc_q.push_back(last_acc);
    end
    @(negedge CLK);
    req_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [VW-1:0] vec_a, vec_r;
  int            waited;

  initial begin
    for (int i = 0; i < LANES; i++) vec_a[i*N +: N] = N'(16'h1000 + i);

    repeat (3) @(negedge CLK);
    // Reset state, observed while reset is still asserted.
    check("rst_req_ready", VW'(req_ready), VW'(1));
    check("rst_busy", VW'(busy), '0);
    check("rst_mem_en", VW'({mem_en, mem_we, mem_addr, mem_wdata}), '0);
    check("rst_resp", VW'({resp_valid, resp_rdata}), '0);
    RST = 1'b1;
    @(negedge CLK);

    // Store 0x1000+i at base 0x0010; resp_rdata stays 0.
    issue(1'b1, 16'h0010, vec_a, '0, 1'b1, LANES);

    // Load it back; busy held through cycles 1..17 after accept.
    issue(1'b0, 16'h0010, '0, vec_a, 1'b1, LANES);
    for (int k = 1; k <= 17; k++) begin
      check("load_busy", VW'(busy), VW'(1));
      @(negedge CLK);
    end

    // Store across the top of the address space.
    vec_r = '0;
    for (int i = 0; i < LANES; i++) vec_r[i*N +: N] = N'(16'hA500 + i);
    issue(1'b1, 16'hFFFE, vec_r, '0, 1'b1, LANES);

    // Request held with changing address while busy: only the first executes.
    issue(1'b1, 16'h0100, vec_r, '0, 1'b1, LANES);
    waited = 0;
    while (busy && waited < 100) begin
      req_valid = 1'b1; req_write = 1'b1;
      req_addr  = AW'($urandom_range(0, 65535));
      @(negedge CLK);
      waited++;
    end
    issue(1'b1, 16'h0200, vec_a, '0, 1'b1, LANES);
    check("b2b_accept_cycle", VW'(last_acc), VW'(last_resp_cyc + 2));

    // Reset during READ lane 7, then a clean load.
    issue(1'b0, 16'h0010, '0, '0, 1'b0, 8);
    repeat (7) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    check("midrst_mem_en", VW'(mem_en), '0);
    check("midrst_busy", VW'(busy), '0);
    check("midrst_resp_valid", VW'(resp_valid), '0);
    check("midrst_resp_rdata", resp_rdata, '0);
    model_rdata = '0;
    @(negedge CLK);
    #2 RST = 1'b1;
    @(negedge CLK);
    issue(1'b0, 16'h0010, '0, vec_a, 1'b1, LANES);

    // Random store/load pairs.
    for (int it = 0; it < 100; it++) begin
      logic [AW-1:0] b;
      b = AW'($urandom_range(0, 65535));
      for (int i = 0; i < LANES; i++) vec_r[i*N +: N] = N'($urandom_range(0, 65535));
      issue(1'b1, b, vec_r, '0, 1'b1, LANES);
      issue(1'b0, b, '0, vec_r, 1'b1, LANES);
    end

    // Drain outstanding expectations with a bounded wait.
    waited = 0;
    while ((exp_q.size() != 0 || exp_mem_q.size() != 0) && waited < 200) begin
      @(negedge CLK);
      waited++;
    end
    check("resp_left", VW'(exp_q.size()), '0);
    check("mem_left", VW'(exp_mem_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
